console_wb: RTL
===============

# console_wb

Wishbone-slave console peripheral for the 7-bit console channel that the debug-bus multiplexer carves out of the shared serial link. It receives console characters from the mux's console output (bit 7 already stripped) into an RX FIFO, and drains CPU-written characters from a TX FIFO into the mux's console input using its busy handshake. It sits between the multiplexer and the CPU bus, with level interrupts for RX-available and TX-empty.

## Interface
- LGFLEN, 4: log2 FIFO depth for both RX and TX; legal range 1..7.
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined request.
- i_wb_addr  in  2  register select.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte enables; a write takes effect only if i_wb_sel[0]=1.
- o_wb_stall  out  1  constant 0.
- o_wb_ack  out  1  one-cycle acknowledge.
- o_wb_data  out  32  read data, valid with o_wb_ack.
- i_rx_stb  in  1  console character from the mux; no backpressure.
- i_rx_data  in  7  console character.
- o_tx_stb  out  1  character offered to the mux.
- o_tx_data  out  7  offered character.
- i_tx_busy  in  1  mux busy; a transfer completes on any cycle with o_tx_stb=1 and i_tx_busy=0.
- o_rx_int  out  1  RX FIFO non-empty.
- o_tx_int  out  1  TX FIFO and output stage both empty.

## Operation
- Registers:
  - 0 STATUS (R): [31:28]=LGFLEN; [23:16]=RX fill count; [15:8]=TX fill count including the output stage; [2]=TX overflow, sticky; [1]=RX overflow, sticky; [0]=RX non-empty.
  - Write to 0: data[1]=1 clears RX overflow; data[2]=1 clears TX overflow.
  - 1 RXDATA: read returns [8]=RX empty, [6:0]=head character (0 when empty), and pops if non-empty. Writes are ignored.
  - 2 TXDATA: write pushes data[6:0]; data[7] is ignored. If full, the write is dropped and TX overflow is set. Read returns [8]=TX full and [6:0]=0.
  - 3: reads 0; writes ignored.
- RX: i_rx_stb pushes i_rx_data. If RX is full and no pop occurs in the same cycle, the character is dropped and RX overflow is set.
- TX output stage: o_tx_stb and o_tx_data are registers. On a completed transfer, or whenever o_tx_stb=0, the stage loads the TX FIFO head if the FIFO is non-empty; otherwise o_tx_stb clears. o_tx_data is held stable while o_tx_stb=1 and i_tx_busy=1.
- Fill counts are LGFLEN+1 bits, zero-extended. The TX fill count reaches 2^LGFLEN+1 when the FIFO is full and the stage is occupied.

## Timing
- Reset values: o_wb_ack=0, o_wb_data=0, o_tx_stb=0, o_tx_data=0, o_rx_int=0, o_tx_int=1; FIFOs empty; overflow flags clear.
- Bus: o_wb_ack is asserted on the cycle after every i_wb_stb with i_wb_cyc=1, regardless of i_wb_we. It is not generated when i_wb_cyc=0. Back-to-back requests are acknowledged back-to-back.
- Read data reflects state at the request cycle. Pops, pushes and flag clears take effect at the same clock edge that registers the ack.
- TX latency: a TXDATA write with stb in cycle n, into an empty FIFO with an idle stage, gives o_tx_stb=1 in cycle n+2. With continuous non-busy draining, o_tx_stb stays high and one character transfers per cycle.
- Simultaneous events:
  - RX full with push and pop in the same cycle: push accepted, no overflow.
  - RX empty with push and RXDATA read in the same cycle: the read returns empty and the character is stored.
  - TX full, with a completed transfer and a push in the same cycle: push accepted.
- Overflow set and clear in the same cycle: set wins.
- Pointer wrap is modulo 2^LGFLEN; full and empty are distinguished by the extra count bit.
- Asserting reset mid-transfer drops o_tx_stb immediately, without waiting for the clock.

## Structure
- Shared package console_wb_pkg: register addresses (ADDR_STATUS/RXDATA/TXDATA) and STATUS/RXDATA bit positions.
- Sub-module console_fifo: synchronous FIFO (BW=7, LGFLEN) with an asynchronous active-low reset.
  - Outputs: first-word-fall-through head, fill count, full/empty.
  - Instantiated twice, once for RX and once for TX.

## Test plan
- Reset, then read STATUS -> 0x4000_0000 with LGFLEN=4; o_tx_int=1, o_rx_int=0.
- Push RX 'A'(0x41), 'B'(0x42); read RXDATA twice, then a third time -> 0x041, 0x042, then 0x100; o_rx_int falls after the second ack.
- Write TXDATA 0x1C3 with i_tx_busy=1 for 5 cycles -> o_tx_stb=1 from cycle n+2 with o_tx_data=0x43 held; exactly one transfer after busy drops; o_tx_int returns to 1.
- Send 17 RX characters without reading -> STATUS RX count=16 and bit1=1; write STATUS 0x2 -> bit1 clears; RXDATA returns the first 16 characters in order.
- Write 18 TXDATA values with i_tx_busy=1 -> TX count=17 and bit2=1; release busy -> 17 characters drained in order.
- Drop i_reset_n while o_tx_stb=1 and the RX FIFO is half full -> all outputs take their reset values asynchronously; STATUS reads counts 0 after release.

Source files
------------

// File: rtl/console_wb_pkg.sv
// Shared register map and bit positions for the console Wishbone peripheral.
package console_wb_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_RXDATA = 2'd1;
    localparam logic [1:0] ADDR_TXDATA = 2'd2;

    localparam int STAT_LGFLEN_LSB = 28;
    localparam int STAT_RXCNT_LSB  = 16;
    localparam int STAT_TXCNT_LSB  = 8;
    localparam int STAT_TXOVF      = 2;
    localparam int STAT_RXOVF      = 1;
    localparam int STAT_RXAVAIL    = 0;

    localparam int RXD_EMPTY = 8;
    localparam int TXD_FULL  = 8;

endpackage

// File: rtl/console_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module console_fifo #(
    parameter int BW     = 7,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_full,
    output logic              o_empty
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam logic [LGFLEN-1:0] PTR_ONE  = LGFLEN'(1);
    localparam logic [LGFLEN:0]   FILL_ONE = (LGFLEN+1)'(1);

    logic [BW-1:0]     mem [DEPTH];
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   fill_q, fill_d;
    logic              w_en, r_en;

    assign o_empty = (fill_q == '0);
    assign o_full  = fill_q[LGFLEN];
    assign o_fill  = fill_q;
    assign o_data  = mem[rd_ptr_q];

    assign r_en = i_rd && !o_empty;
    assign w_en = i_wr && (!o_full || r_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (w_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (r_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({w_en, r_en})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (w_en) mem[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/console_wb.sv
// Wishbone console peripheral: RX FIFO fed by the mux console output, TX FIFO
// drained through a registered output stage into the mux busy handshake.
module console_wb
    import console_wb_pkg::*;
#(
    parameter int LGFLEN = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_rx_stb,
    input  logic [6:0]  i_rx_data,
    output logic        o_tx_stb,
    output logic [6:0]  o_tx_data,
    input  logic        i_tx_busy,
    output logic        o_rx_int,
    output logic        o_tx_int
);

    logic              wb_req, wb_wr;
    logic              rx_pop, tx_push, tx_pop, tx_load;
    logic              clr_rx_ovf, clr_tx_ovf;
    logic [6:0]        rx_head, tx_head;
    logic [LGFLEN:0]   rx_fill, tx_fill, tx_count;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [31:0]       rdata;

    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              tx_stb_q, tx_stb_d;
    logic [6:0]        tx_data_q, tx_data_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_q, tx_ovf_d;

    logic unused_bits;
    assign unused_bits = &{1'b0, i_wb_data[31:7], i_wb_sel[3:1]};

    assign wb_req     = i_wb_cyc && i_wb_stb;
    assign wb_wr      = wb_req && i_wb_we && i_wb_sel[0];
    assign rx_pop     = wb_req && !i_wb_we && (i_wb_addr == ADDR_RXDATA) && !rx_empty;
    assign tx_push    = wb_wr && (i_wb_addr == ADDR_TXDATA);
    assign clr_rx_ovf = wb_wr && (i_wb_addr == ADDR_STATUS) && i_wb_data[STAT_RXOVF];
    assign clr_tx_ovf = wb_wr && (i_wb_addr == ADDR_STATUS) && i_wb_data[STAT_TXOVF];

    // The stage refills after a completed transfer or whenever it is idle.
    assign tx_load  = !tx_stb_q || !i_tx_busy;
    assign tx_pop   = tx_load && !tx_empty;
    assign tx_count = tx_fill + (LGFLEN+1)'(tx_stb_q);

    console_fifo #(.BW(7), .LGFLEN(LGFLEN)) u_rx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr      (i_rx_stb),
        .i_data    (i_rx_data),
        .i_rd      (rx_pop),
        .o_data    (rx_head),
        .o_fill    (rx_fill),
        .o_full    (rx_full),
        .o_empty   (rx_empty)
    );

    console_fifo #(.BW(7), .LGFLEN(LGFLEN)) u_tx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr      (tx_push),
        .i_data    (i_wb_data[6:0]),
        .i_rd      (tx_pop),
        .o_data    (tx_head),
        .o_fill    (tx_fill),
        .o_full    (tx_full),
        .o_empty   (tx_empty)
    );

    always_comb begin
        rdata = '0;
        case (i_wb_addr)
            ADDR_STATUS: begin
                rdata[STAT_LGFLEN_LSB +: 4] = 4'(LGFLEN);
                rdata[STAT_RXCNT_LSB +: 8]  = 8'(rx_fill);
                rdata[STAT_TXCNT_LSB +: 8]  = 8'(tx_count);
                rdata[STAT_TXOVF]           = tx_ovf_q;
                rdata[STAT_RXOVF]           = rx_ovf_q;
                rdata[STAT_RXAVAIL]         = !rx_empty;
            end
            ADDR_RXDATA: begin
                rdata[RXD_EMPTY] = rx_empty;
                rdata[6:0]       = rx_empty ? 7'd0 : rx_head;
            end
            ADDR_TXDATA: rdata[TXD_FULL] = tx_full;
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        ack_d     = wb_req;
        rdata_d   = wb_req ? rdata : '0;
        tx_stb_d  = tx_stb_q;
        tx_data_d = tx_data_q;
        if (tx_load) begin
            tx_stb_d = !tx_empty;
            if (!tx_empty) tx_data_d = tx_head;
        end
        // A same-cycle overflow outranks a software clear.
        rx_ovf_d = (rx_ovf_q && !clr_rx_ovf) || (i_rx_stb && rx_full && !rx_pop);
        tx_ovf_d = (tx_ovf_q && !clr_tx_ovf) || (tx_push && tx_full && !tx_pop);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            tx_stb_q  <= 1'b0;
            tx_data_q <= '0;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            tx_stb_q  <= tx_stb_d;
            tx_data_q <= tx_data_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_ovf_q  <= tx_ovf_d;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_tx_stb   = tx_stb_q;
    assign o_tx_data  = tx_data_q;
    assign o_rx_int   = !rx_empty;
    assign o_tx_int   = tx_empty && !tx_stb_q;

endmodule
